fifo_wr_arb: RTL and testbench

//  Round-robin write arbiter sharing one FIFO write port (fifo_if driver side) among NUM_REQ sources.

---
 rtl/fifo_wr_arb.sv | 97 +++++++++
 tb/tb_fifo_wr_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready sources.
// A grant lasts for up to MAX_BURST words. The FIFO full/almost_full flags stall the granted source.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int USE_AFULL  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_almost_full,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   last_reg, last_next;
  logic [CW-1:0]   burst_reg, burst_next;
  logic [GW-1:0]   pick, cand;
  logic            stall, granted, release_now;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  assign stall   = fifo_full | ((USE_AFULL != 0) & fifo_almost_full);
  assign granted = (state_reg == GRANT);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign words[gi]     = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready[gi] = granted & (grant_reg == GW'(gi)) & ~stall;
  end

  assign fifo_wr   = granted & req_valid[grant_reg] & ~stall;
  assign fifo_data = fifo_wr ? words[grant_reg] : '0;
  assign grant_id  = grant_reg;
  assign busy      = granted;

  // Walk from farthest to nearest so the nearest valid index after last wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_reg) + k) % NUM_REQ);
      if (req_valid[cand]) pick = cand;
    end
  end

  assign release_now = (fifo_wr && (burst_reg == CW'(MAX_BURST - 1))) || !req_valid[grant_reg];

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    burst_next = burst_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          grant_next = pick;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (fifo_wr) burst_next = burst_reg + CW'(1);
        if (release_now) begin
          state_next = IDLE;
          last_next  = grant_reg;
          burst_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= GW'(NUM_REQ - 1);
      burst_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      burst_reg <= burst_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed, table-driven bench for fifo_wr_arb; a second instance with USE_AFULL=0 covers stall selection.
// Each source produces words {source, sequence}, so the expected FIFO data shows per-source order.
module tb_fifo_wr_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data;
  logic        afull = 1'b0, full = 1'b0;
  logic [3:0]  req_ready, req_ready_b;
  logic        fifo_wr, fifo_wr_b, busy, busy_b;
  logic [7:0]  fifo_data, fifo_data_b;
  logic [1:0]  grant_id, grant_id_b;
  logic [3:0]  cnt [4];

  int n_checks = 0;
  int n_fail   = 0;
  int row      = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .USE_AFULL(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_almost_full(afull), .fifo_full(full),
    .grant_id(grant_id), .busy(busy));

  fifo_wr_arb #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .USE_AFULL(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready_b),
    .fifo_wr(fifo_wr_b), .fifo_data(fifo_data_b), .fifo_almost_full(afull), .fifo_full(full),
    .grant_id(grant_id_b), .busy(busy_b));

  for (genvar gi = 0; gi < 4; gi++) begin : g_src
    assign req_data[gi*8 +: 8] = {4'(gi), cnt[gi]};
    always @(posedge clk) begin
      if (rst) cnt[gi] <= '0;
      else if (req_valid[gi] && req_ready[gi]) cnt[gi] <= cnt[gi] + 4'd1;
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       afull;
    logic       full;
    logic       wr;
    logic [7:0] data;
    logic [3:0] ready;
    logic [1:0] gid;
    logic       busy;
    logic       chk_b;
    logic       b_wr;
    logic [3:0] b_ready;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic af, logic f,
                              logic w, logic [7:0] d, logic [3:0] rd, logic [1:0] g, logic b);
    vec_t t;
    t.rst = r; t.valid = v; t.afull = af; t.full = f;
    t.wr = w; t.data = d; t.ready = rd; t.gid = g; t.busy = b;
    t.chk_b = 1'b0; t.b_wr = 1'b0; t.b_ready = '0;
    return t;
  endfunction

  function automatic vec_t mkb(vec_t t, logic bw, logic [3:0] br);
    vec_t u = t;
    u.chk_b = 1'b1; u.b_wr = bw; u.b_ready = br;
    return u;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0h required %0h", row, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check on the falling edge.
  task automatic apply(input vec_t v);
    rst = v.rst; req_valid = v.valid; afull = v.afull; full = v.full;
    @(negedge clk);
    chk("fifo_wr", 8'(fifo_wr), 8'(v.wr));
    chk("fifo_data", fifo_data, v.data);
    chk("req_ready", 8'(req_ready), 8'(v.ready));
    chk("grant_id", 8'(grant_id), 8'(v.gid));
    chk("busy", 8'(busy), 8'(v.busy));
    chk("wr_while_full", 8'(fifo_wr & full), 8'd0);
    chk("ready_onehot0", 8'($onehot0(req_ready)), 8'd1);
    if (v.chk_b) begin
      chk("b_fifo_wr", 8'(fifo_wr_b), 8'(v.b_wr));
      chk("b_req_ready", 8'(req_ready_b), 8'(v.b_ready));
    end
    $display("row %0d rst=%0b valid=%b af=%0b full=%0b -> wr=%0b data=%h ready=%b gid=%0d busy=%0b",
             row, rst, req_valid, afull, full, fifo_wr, fifo_data, req_ready, grant_id, busy);
    wr_count += int'(fifo_wr);
    row++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t r, v;
    r = mk(1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0);

    // Single source, 6 words: burst of 4, one-cycle bubble, then 2 more.
    tbl.push_back(r);
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h00, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h01, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h02, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h03, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h04, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h05, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));

    // Full for 3 cycles after the 2nd word: grant and burst count held.
    tbl.push_back(r);
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h00, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h01, 4'b0001, 2'd0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b0001, 0, 1, 0, 8'h00, 4'b0000, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h02, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 1, 8'h03, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));

    // req2 drops after 2 words; rotation then prefers 3 over 0, then 0.
    tbl.push_back(r);
    tbl.push_back(mk(0, 4'b0100, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 0, 1, 8'h20, 4'b0100, 2'd2, 1));
    tbl.push_back(mk(0, 4'b0101, 0, 0, 1, 8'h21, 4'b0100, 2'd2, 1));
    tbl.push_back(mk(0, 4'b1001, 0, 0, 0, 8'h00, 4'b0100, 2'd2, 1));
    tbl.push_back(mk(0, 4'b1001, 0, 0, 0, 8'h00, 4'b0000, 2'd2, 0));
    tbl.push_back(mk(0, 4'b1001, 0, 0, 1, 8'h30, 4'b1000, 2'd3, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 8'h00, 4'b1000, 2'd3, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 8'h00, 4'b0000, 2'd3, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));

    // almost_full: the USE_AFULL=1 instance stalls, the USE_AFULL=0 instance keeps writing.
    tbl.push_back(r);
    tbl.push_back(mkb(mk(0, 4'b0001, 1, 0, 0, 8'h00, 4'b0000, 2'd0, 0), 0, 4'b0000));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkb(mk(0, 4'b0001, 1, 0, 0, 8'h00, 4'b0000, 2'd0, 1), 1, 4'b0001));
    tbl.push_back(mkb(mk(0, 4'b0001, 0, 0, 1, 8'h00, 4'b0001, 2'd0, 1), 1, 4'b0001));
    tbl.push_back(mkb(mk(0, 4'b0001, 0, 0, 1, 8'h01, 4'b0001, 2'd0, 1), 0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));

    // Reset mid-burst on req1: outputs clear at once, next search starts at 0.
    tbl.push_back(r);
    tbl.push_back(mk(0, 4'b0010, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 0, 1, 8'h10, 4'b0010, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 0, 1, 8'h11, 4'b0010, 2'd1, 1));
    tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 1, 8'h00, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 1, 8'h01, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 2'd0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // All four sources continuously valid: grants 0,1,2,3, each preceded by one idle cycle.
    apply(r);
    wr_count = 0;
    for (int k = 0; k < 20; k++) begin
      int g, ph;
      g  = k / 5;
      ph = k % 5;
      if (ph == 0)
        v = mk(0, 4'b1111, 0, 0, 0, 8'h00, 4'b0000, (g == 0) ? 2'd0 : 2'(g - 1), 0);
      else
        v = mk(0, 4'b1111, 0, 0, 1, 8'(g * 16 + ph - 1), 4'(1 << g), 2'(g), 1);
      apply(v);
    end
    chk("writes_in_20_cycles", 8'(wr_count), 8'd16);
    apply(mk(0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 2'd3, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
